// File: rtl/nn_engine_pkg.sv
// Shared definitions for the CORDIC neuron engine control path.
// Latency: n/a (types, constants and a config check helper only).
// Backpressure: n/a.
package nn_engine_pkg;

  localparam int MAX_LAYERS  = 5;
  localparam int MAX_NEURONS = 64;
  localparam int MAC_LAT     = 16;
  localparam int AF_LAT      = 16;

  // Lane/index width; layer-width config is one bit wider so a full
  // 64-lane layer, and an out-of-range 65, can both be expressed.
  localparam int IDX_W = 6;
  localparam int CFG_W = 7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR,
    ST_LD_WT,
    ST_MAC,
    ST_SHIFT,
    ST_LD_BIAS,
    ST_BADD,
    ST_ACT,
    ST_WRBK,
    ST_DONE
  } seq_state_e;

  // A layer width is usable when it is 1..MAX_NEURONS.
  function automatic logic width_ok(input logic [CFG_W-1:0] w);
    return (w != '0) && (w <= CFG_W'(MAX_NEURONS));
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Loadable up-counter with a terminal-count flag.
// Latency: count updates one cycle after load/inc; term_o is combinational on the count.
// Backpressure: none; the counter only advances when inc_i is high.
module seq_counter
  import nn_engine_pkg::*;
#(
  parameter int W = IDX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_val_i,
  output logic [W-1:0] cnt_o,
  output logic         term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: a load takes priority over an increment.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/layer_sequencer.sv
// Layer-by-layer sequencer driving weight/bias load, MAC, activation and output bank.
// Latency: per layer 1 + nin*(nl+MAC) + (nin-1) + nl + 2 + AF cycles, plus one DONE cycle.
// Backpressure: LD_WT / LD_BIAS stall indefinitely while wt_valid / bias_valid are low.
module layer_sequencer
  import nn_engine_pkg::*;
#(
  parameter int MAC_CYC = nn_engine_pkg::MAC_LAT,
  parameter int AF_CYC  = nn_engine_pkg::AF_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       no_layers,
  input  logic [CFG_W-1:0] n_in,
  input  logic [CFG_W-1:0] nl1,
  input  logic [CFG_W-1:0] nl2,
  input  logic [CFG_W-1:0] nl3,
  input  logic [CFG_W-1:0] nl4,
  input  logic [CFG_W-1:0] nl5,
  input  logic             wt_valid,
  input  logic             bias_valid,
  output logic             weight_en,
  output logic             bias_en,
  output logic             bias_sign,
  output logic             compute_en,
  output logic             af_en,
  output logic             out_shft_en,
  output logic             out_wr_en,
  output logic             output_sig,
  output logic             busy,
  output logic             tot_complete,
  output logic             cfg_err,
  output logic [IDX_W-1:0] n,
  output logic [IDX_W-1:0] i
);

  localparam logic [IDX_W-1:0] MAC_TERM = IDX_W'(MAC_CYC - 1);
  localparam logic [IDX_W-1:0] AF_TERM  = IDX_W'(AF_CYC - 1);

  seq_state_e state_q, state_d;

  logic [5:0]            no_layers_q;
  logic [CFG_W-1:0]      n_in_q;
  logic [4:0][CFG_W-1:0] nl_q;
  logic                  cfg_err_q, cfg_err_d;

  logic             cfg_ok, accept;
  logic [CFG_W-1:0] nin_cur, nl_cur;
  logic             wt_acc, bs_acc;

  logic             wcnt_load, wcnt_inc, wcnt_term;
  logic             lat_load, lat_term;
  logic             i_load, i_inc, i_term;
  logic             n_load, n_inc, n_term;
  logic [IDX_W-1:0] lat_term_val;
  logic [IDX_W-1:0] wcnt_val, lat_val, i_val, n_val;

  // wcnt and lat are only consumed through their terminal flags.
  logic [2*IDX_W-1:0] unused_cnt;
  assign unused_cnt = {wcnt_val, lat_val};

  // Only the layers actually used need a legal width.
  assign cfg_ok = (no_layers != 6'd0) && (no_layers <= 6'(MAX_LAYERS))
                && width_ok(n_in) && width_ok(nl1)
                && ((no_layers < 6'd2) || width_ok(nl2))
                && ((no_layers < 6'd3) || width_ok(nl3))
                && ((no_layers < 6'd4) || width_ok(nl4))
                && ((no_layers < 6'd5) || width_ok(nl5));

  assign accept = (state_q == ST_IDLE) && start && cfg_ok;
  assign wt_acc = (state_q == ST_LD_WT) && wt_valid;
  assign bs_acc = (state_q == ST_LD_BIAS) && bias_valid;

  // Current layer input width (previous layer width, or n_in for layer 0) and output width.
  always_comb begin
    nin_cur = n_in_q;
    nl_cur  = nl_q[0];
    case (n_val)
      6'd1: begin nin_cur = nl_q[0]; nl_cur = nl_q[1]; end
      6'd2: begin nin_cur = nl_q[1]; nl_cur = nl_q[2]; end
      6'd3: begin nin_cur = nl_q[2]; nl_cur = nl_q[3]; end
      6'd4: begin nin_cur = nl_q[3]; nl_cur = nl_q[4]; end
      default: begin nin_cur = n_in_q; nl_cur = nl_q[0]; end
    endcase
  end

  // Counter controls: word and latency counters idle at zero outside their phases.
  always_comb begin
    wcnt_load    = !((state_q == ST_LD_WT) || (state_q == ST_LD_BIAS));
    wcnt_inc     = wt_acc || bs_acc;
    lat_load     = !((state_q == ST_MAC) || (state_q == ST_ACT));
    lat_term_val = (state_q == ST_ACT) ? AF_TERM : MAC_TERM;
    i_load       = accept || (state_q == ST_CLR);
    i_inc        = (state_q == ST_SHIFT);
    n_load       = accept;
    n_inc        = (state_q == ST_WRBK) && !n_term;
  end

  seq_counter #(.W(IDX_W)) u_wcnt (
    .clk(clk), .rst(rst), .load_i(wcnt_load), .load_val_i('0), .inc_i(wcnt_inc),
    .term_val_i(IDX_W'(nl_cur - CFG_W'(1))), .cnt_o(wcnt_val), .term_o(wcnt_term)
  );

  seq_counter #(.W(IDX_W)) u_lat (
    .clk(clk), .rst(rst), .load_i(lat_load), .load_val_i('0), .inc_i(1'b1),
    .term_val_i(lat_term_val), .cnt_o(lat_val), .term_o(lat_term)
  );

  seq_counter #(.W(IDX_W)) u_icnt (
    .clk(clk), .rst(rst), .load_i(i_load), .load_val_i('0), .inc_i(i_inc),
    .term_val_i(IDX_W'(nin_cur - CFG_W'(1))), .cnt_o(i_val), .term_o(i_term)
  );

  seq_counter #(.W(IDX_W)) u_ncnt (
    .clk(clk), .rst(rst), .load_i(n_load), .load_val_i('0), .inc_i(n_inc),
    .term_val_i(no_layers_q - 6'd1), .cnt_o(n_val), .term_o(n_term)
  );

  assign cfg_err_d = (state_q == ST_IDLE) && start && !cfg_ok;

  // State, latched configuration and the reject pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      no_layers_q <= '0;
      n_in_q      <= '0;
      nl_q        <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_err_d;
      if (accept) begin
        no_layers_q <= no_layers;
        n_in_q      <= n_in;
        nl_q        <= {nl5, nl4, nl3, nl2, nl1};
      end
    end
  end

  // Next-state: counted phases, stalls in the two load phases.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_CLR;
      ST_CLR:     state_d = ST_LD_WT;
      ST_LD_WT:   if (wt_acc && wcnt_term) state_d = ST_MAC;
      ST_MAC:     if (lat_term) state_d = i_term ? ST_LD_BIAS : ST_SHIFT;
      ST_SHIFT:   state_d = ST_LD_WT;
      ST_LD_BIAS: if (bs_acc && wcnt_term) state_d = ST_BADD;
      ST_BADD:    state_d = ST_ACT;
      ST_ACT:     if (lat_term) state_d = ST_WRBK;
      ST_WRBK:    state_d = n_term ? ST_DONE : ST_CLR;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Decoded outputs; only weight_en/bias_en look at the valid strobes.
  always_comb begin
    weight_en    = wt_acc;
    bias_en      = bs_acc || (state_q == ST_BADD);
    bias_sign    = (state_q == ST_BADD);
    compute_en   = !((state_q == ST_IDLE) || (state_q == ST_CLR) || (state_q == ST_DONE));
    af_en        = (state_q == ST_ACT);
    output_sig   = (n_val != '0) && (state_q != ST_IDLE) && (state_q != ST_DONE);
    out_shft_en  = (state_q == ST_SHIFT) && output_sig;
    out_wr_en    = (state_q == ST_WRBK);
    busy         = (state_q != ST_IDLE);
    tot_complete = (state_q == ST_DONE);
  end

  assign cfg_err = cfg_err_q;
  assign n       = n_val;
  assign i       = i_val;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: each start pushes an expected run summary,
// a negedge monitor accumulates enables and compares on tot_complete / cfg_err.
module tb_layer_sequencer;
  import nn_engine_pkg::*;

  logic       clk, rst, start, wt_valid, bias_valid;
  logic [5:0] no_layers;
  logic [6:0] n_in, nl1, nl2, nl3, nl4, nl5;
  logic       weight_en, bias_en, bias_sign, compute_en, af_en, out_shft_en, out_wr_en;
  logic       output_sig, busy, tot_complete, cfg_err;
  logic [5:0] n, i;

  layer_sequencer #(.MAC_CYC(4), .AF_CYC(4)) dut (
    .clk(clk), .rst(rst), .start(start), .no_layers(no_layers), .n_in(n_in),
    .nl1(nl1), .nl2(nl2), .nl3(nl3), .nl4(nl4), .nl5(nl5),
    .wt_valid(wt_valid), .bias_valid(bias_valid),
    .weight_en(weight_en), .bias_en(bias_en), .bias_sign(bias_sign), .compute_en(compute_en),
    .af_en(af_en), .out_shft_en(out_shft_en), .out_wr_en(out_wr_en), .output_sig(output_sig),
    .busy(busy), .tot_complete(tot_complete), .cfg_err(cfg_err), .n(n), .i(i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string name;
    int    kind;   // 2: tot_complete, 1: cfg_err
    int    start_cyc;
    int    lat;
    int    busy;
    int    wen;
    int    ben;
    int    wr;
    int    sh;
    int    clr;
    int    imax;
    int    nmax;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   tog = 1'b0;
  bit   acc_last = 1'b0;
  int   busy_a, wen_a, ben_a, wr_a, sh_a, clr_a, conf_a, imax_a, nmax_a;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic clr_acc();
    busy_a = 0; wen_a = 0; ben_a = 0; wr_a = 0; sh_a = 0;
    clr_a = 0; conf_a = 0; imax_a = 0; nmax_a = 0;
  endtask

  initial clr_acc();

  // Monitor: accumulate per-run activity, compare when the DUT signals an outcome.
  always @(negedge clk) begin
    acc_last = weight_en;
    if (rst) begin
      clr_acc();
    end else begin
      if (busy) busy_a++;
      if (weight_en) wen_a++;
      if (bias_en && !bias_sign) ben_a++;
      if (out_wr_en) wr_a++;
      if (out_shft_en) sh_a++;
      if (out_wr_en && out_shft_en) conf_a++;
      if (busy && !compute_en && !tot_complete) clr_a++;
      if (busy && int'(i) > imax_a) imax_a = int'(i);
      if (busy && int'(n) > nmax_a) nmax_a = int'(n);
      if (tot_complete || cfg_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_outcome", int'({tot_complete, cfg_err}), 0);
        end else begin
          cur = exp_q.pop_front();
          chk({cur.name, "_kind"}, int'({tot_complete, cfg_err}), cur.kind);
          chk({cur.name, "_latency"}, cyc - cur.start_cyc + 1, cur.lat);
          chk({cur.name, "_busy_cycles"}, busy_a, cur.busy);
          chk({cur.name, "_weight_en"}, wen_a, cur.wen);
          chk({cur.name, "_bias_load"}, ben_a, cur.ben);
          chk({cur.name, "_out_wr_en"}, wr_a, cur.wr);
          chk({cur.name, "_out_shft_en"}, sh_a, cur.sh);
          chk({cur.name, "_wr_shft_overlap"}, conf_a, 0);
          chk({cur.name, "_compute_low"}, clr_a, cur.clr);
          chk({cur.name, "_i_max"}, imax_a, cur.imax);
          chk({cur.name, "_n_max"}, nmax_a, cur.nmax);
        end
        clr_acc();
      end
    end
  end

  // Weight source: either always valid, or drops for one cycle after every accepted word.
  initial begin
    wt_valid = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      wt_valid = tog ? !acc_last : 1'b1;
    end
  end

  task automatic set_cfg(input int nlay, input int ni, input int a, input int b,
                         input int c, input int d, input int e);
    no_layers = 6'(nlay);
    n_in = 7'(ni);
    nl1 = 7'(a); nl2 = 7'(b); nl3 = 7'(c); nl4 = 7'(d); nl5 = 7'(e);
  endtask

  task automatic run(input string nm, input bit push, input int kind, input int lat,
                     input int bsy, input int wen, input int ben, input int wr,
                     input int sh, input int clr, input int imax, input int nmax);
    exp_t e;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (push) begin
      e.name = nm; e.kind = kind; e.start_cyc = cyc; e.lat = lat; e.busy = bsy;
      e.wen = wen; e.ben = ben; e.wr = wr; e.sh = sh; e.clr = clr;
      e.imax = imax; e.nmax = nmax;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string nm, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: still busy=%0d pending=%0d after %0d cycles", nm, busy, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_outputs"}, int'({weight_en, bias_en, bias_sign, compute_en, af_en, out_shft_en,
                                out_wr_en, output_sig, busy, tot_complete, cfg_err}), 0);
    chk({nm, "_n"}, int'(n), 0);
    chk({nm, "_i"}, int'(i), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bias_valid = 1'b1;
    set_cfg(2, 2, 3, 1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2 chk_quiet("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // T1: 2 layers (2->3->1), latency 25+25+1 with DONE.
    run("t1", 1'b1, 2, 51, 51, 9, 4, 2, 2, 2, 2, 1);
    wait_idle("t1", 200);

    // T2: one-cycle stall after each weight word; layer 0 has 2 bursts of 3 -> 4 stalls.
    tog = 1'b1;
    run("t2", 1'b1, 2, 55, 55, 9, 4, 2, 2, 2, 2, 1);
    wait_idle("t2", 200);
    tog = 1'b0;

    // T3: rejected configurations.
    set_cfg(0, 2, 3, 1, 0, 0, 0);
    run("t3_nolayers0", 1'b1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    wait_idle("t3a", 20);
    set_cfg(2, 2, 3, 0, 0, 0, 0);
    run("t3_nl2zero", 1'b1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    wait_idle("t3b", 20);
    set_cfg(2, 65, 3, 1, 0, 0, 0);
    run("t3_nin65", 1'b1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    wait_idle("t3c", 20);

    // T4: reset during layer-0 activation (cycles 20..23 after start), then a clean rerun.
    set_cfg(2, 2, 3, 1, 0, 0, 0);
    run("t4_abort", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (21) @(posedge clk);
    #2 chk("t4_in_act", int'(af_en), 1);
    rst = 1'b1;
    #1 chk_quiet("t4_abort");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run("t4_rerun", 1'b1, 2, 51, 51, 9, 4, 2, 2, 2, 2, 1);
    wait_idle("t4", 200);

    // T5: extra start and nl1 change during layer 1 must not disturb the run.
    run("t5", 1'b1, 2, 51, 51, 9, 4, 2, 2, 2, 2, 1);
    repeat (30) @(posedge clk);
    #1 start = 1'b1;
    nl1 = 7'd10;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle("t5", 200);
    nl1 = 7'd3;

    // T6: 5 full layers of 64: per layer 1+64*68+63+64+2+4 = 4486.
    set_cfg(5, 64, 64, 64, 64, 64, 64);
    run("t6", 1'b1, 2, 22431, 22431, 20480, 320, 5, 252, 5, 63, 4);
    wait_idle("t6", 30000);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
